// File: rtl/bus_decoder.sv
// Registered address decoder and response router between the core data port
// and N memory-mapped slaves; unmapped or silent slaves return an error response.
module bus_decoder #(
    parameter int                      N_SLAVES   = 4,
    parameter int                      DATA_W     = 32,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {32'h8000_2000, 32'h8000_1000,
                                                     32'h8000_0800, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                     32'hFFFF_FFFC, 32'hFFFF_FF00},
    parameter int                      TIMEOUT    = 15
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [DATA_W/8-1:0]          be_i,
    input  logic [31:0]                  addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         ready_o,
    output logic                         err_o,
    output logic [N_SLAVES-1:0]          slv_req_o,
    output logic                         slv_we_o,
    output logic [DATA_W/8-1:0]          slv_be_o,
    output logic [31:0]                  slv_addr_o,
    output logic [DATA_W-1:0]            slv_wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata_i,
    input  logic [N_SLAVES-1:0]          slv_ready_i
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [SEL_W-1:0]       sel_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   err_reg;
    logic                   ready_reg;
    logic [DATA_W-1:0]      rdata_reg;
    logic [N_SLAVES-1:0]    slv_req_reg;
    logic                   slv_we_reg;
    logic [DATA_W/8-1:0]    slv_be_reg;
    logic [31:0]            slv_addr_reg;
    logic [DATA_W-1:0]      slv_wdata_reg;

    logic [N_SLAVES-1:0]    hit_vec;
    logic [31:0]            mask_arr  [N_SLAVES];
    logic [DATA_W-1:0]      rdata_arr [N_SLAVES];
    logic [SEL_W-1:0]       hit_idx;
    logic                   hit_any;
    logic [31:0]            hit_offset;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   sel_ready;

    // Per-slave region match and read-data unpacking.
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
        assign mask_arr[gi]  = SLAVE_MASK[gi*32 +: 32];
        assign hit_vec[gi]   = ((addr_i & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32]);
        assign rdata_arr[gi] = slv_rdata_i[gi*DATA_W +: DATA_W];
    end

    // Descending scan so that the lowest matching index is the one left standing.
    always_comb begin
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_idx = SEL_W'(k);
            end
        end
    end

    assign hit_any    = |hit_vec;
    assign hit_offset = addr_i & ~mask_arr[hit_idx];
    assign sel_rdata  = rdata_arr[sel_reg];
    assign sel_ready  = slv_ready_i[sel_reg];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            rdata_reg     <= '0;
            slv_req_reg   <= '0;
            slv_we_reg    <= 1'b0;
            slv_be_reg    <= '0;
            slv_addr_reg  <= '0;
            slv_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    if (req_i) begin
                        if (hit_any) begin
                            sel_reg       <= hit_idx;
                            slv_we_reg    <= we_i;
                            slv_be_reg    <= be_i;
                            slv_wdata_reg <= wdata_i;
                            slv_addr_reg  <= hit_offset;
                            cnt_reg       <= '0;
                            slv_req_reg   <= N_SLAVES'(1) << hit_idx;
                            state_reg     <= BUSY;
                        end else begin
                            // Miss: answer straight away, no slave is touched.
                            err_reg   <= 1'b1;
                            rdata_reg <= '0;
                            ready_reg <= 1'b1;
                            state_reg <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // Ready is checked first so it beats a coincident timeout.
                    if (sel_ready) begin
                        rdata_reg   <= slv_we_reg ? '0 : sel_rdata;
                        err_reg     <= 1'b0;
                        ready_reg   <= 1'b1;
                        slv_req_reg <= '0;
                        state_reg   <= RESP;
                    end else if ((TIMEOUT != 0) && (cnt_reg == TIMEOUT_C)) begin
                        rdata_reg   <= '0;
                        err_reg     <= 1'b1;
                        ready_reg   <= 1'b1;
                        slv_req_reg <= '0;
                        state_reg   <= RESP;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    ready_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg   <= 1'b0;
                    slv_req_reg <= '0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_reg;
    assign ready_o     = ready_reg;
    assign err_o       = err_reg;
    assign slv_req_o   = slv_req_reg;
    assign slv_we_o    = slv_we_reg;
    assign slv_be_o    = slv_be_reg;
    assign slv_addr_o  = slv_addr_reg;
    assign slv_wdata_o = slv_wdata_reg;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: reset, hit read, wait-state write, miss,
// timeout with a stray ready, and reset in the middle of a transaction.
module tb_bus_decoder;

    logic          clk_i;
    logic          arstn_i;
    logic          req_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          ready_o;
    logic          err_o;
    logic [3:0]    slv_req_o;
    logic          slv_we_o;
    logic [3:0]    slv_be_o;
    logic [31:0]   slv_addr_o;
    logic [31:0]   slv_wdata_o;
    logic [127:0]  slv_rdata_i;
    logic [3:0]    slv_ready_i;

    int checks = 0;
    int errors = 0;

    bus_decoder dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .ready_o     (ready_o),
        .err_o       (err_o),
        .slv_req_o   (slv_req_o),
        .slv_we_o    (slv_we_o),
        .slv_be_o    (slv_be_o),
        .slv_addr_o  (slv_addr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ready_i (slv_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        req_i   = 1'b1;
        addr_i  = 32'h0000_0010;
        arstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL reset_slv_req got %b want 0000", slv_req_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        checks++; if (slv_we_o !== 1'b0) begin errors++; $display("FAIL reset_slv_we got %b want 0", slv_we_o); end
        checks++; if (slv_be_o !== 4'h0) begin errors++; $display("FAIL reset_slv_be got %h want 0", slv_be_o); end
        checks++; if (slv_addr_o !== 32'h0) begin errors++; $display("FAIL reset_slv_addr got %h want 0", slv_addr_o); end
        checks++; if (slv_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_slv_wdata got %h want 0", slv_wdata_o); end
        req_i   = 1'b0;
        arstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL idle_slv_req got %b want 0000", slv_req_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", ready_o); end
        $display("reset: done");
    endtask

    task automatic test_read_s0();
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_0010; wdata_i = 32'h0;
        @(negedge clk_i);  // cycle 1
        checks++; if (slv_req_o !== 4'b0001) begin errors++; $display("FAIL rd_slv_req got %b want 0001", slv_req_o); end
        checks++; if (slv_addr_o !== 32'h10) begin errors++; $display("FAIL rd_slv_addr got %h want 10", slv_addr_o); end
        checks++; if (slv_we_o !== 1'b0) begin errors++; $display("FAIL rd_slv_we got %b want 0", slv_we_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %b want 0", ready_o); end
        slv_ready_i = 4'b0001;
        slv_rdata_i[31:0] = 32'hDEAD_BEEF;
        @(negedge clk_i);  // cycle 2
        slv_ready_i = 4'b0000;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rd_ready got %b want 1", ready_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err_o); end
        checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rdata_o); end
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL rd_req_drop got %b want 0000", slv_req_o); end
        req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse got %b want 0", ready_o); end
        $display("read s0 addr=00000010: rdata=%h err=%b", 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_write_s1_wait();
        req_i = 1'b1; we_i = 1'b1; be_i = 4'b0001; addr_i = 32'h8000_0803; wdata_i = 32'h0000_005A;
        slv_rdata_i[63:32] = 32'h1234_5678;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            checks++; if (slv_req_o !== 4'b0010) begin errors++; $display("FAIL wr_slv_req cycle %0d got %b want 0010", c, slv_req_o); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL wr_early_ready cycle %0d got %b want 0", c, ready_o); end
            if (c == 1) begin
                checks++; if (slv_addr_o !== 32'h3) begin errors++; $display("FAIL wr_slv_addr got %h want 3", slv_addr_o); end
                checks++; if (slv_we_o !== 1'b1) begin errors++; $display("FAIL wr_slv_we got %b want 1", slv_we_o); end
                checks++; if (slv_wdata_o !== 32'h5A) begin errors++; $display("FAIL wr_slv_wdata got %h want 5a", slv_wdata_o); end
                checks++; if (slv_be_o !== 4'b0001) begin errors++; $display("FAIL wr_slv_be got %b want 0001", slv_be_o); end
            end
            if (c == 4) slv_ready_i = 4'b0010;
        end
        @(negedge clk_i);  // cycle 5
        slv_ready_i = 4'b0000;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", ready_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rdata_o); end
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        $display("write s1 addr=80000803: wdata=5a err=%b", 1'b0);
    endtask

    task automatic test_miss();
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h4000_0000;
        @(negedge clk_i);  // cycle 1
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL miss_slv_req got %b want 0000", slv_req_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL miss_ready got %b want 1", ready_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL miss_err got %b want 1", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h want 0", rdata_o); end
        req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL miss_ready_pulse got %b want 0", ready_o); end
        $display("read miss addr=40000000: err=1");
    endtask

    task automatic test_timeout();
        slv_ready_i = 4'b1000;
        slv_rdata_i[127:96] = 32'hBAD0_BAD0;
        slv_rdata_i[95:64]  = 32'h7777_7777;
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h8000_1004;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_i);
            checks++; if (slv_req_o !== 4'b0100) begin errors++; $display("FAIL to_slv_req cycle %0d got %b want 0100", c, slv_req_o); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL to_early_ready cycle %0d got %b want 0", c, ready_o); end
            if (c == 1) begin
                checks++; if (slv_addr_o !== 32'h4) begin errors++; $display("FAIL to_slv_addr got %h want 4", slv_addr_o); end
            end
        end
        @(negedge clk_i);  // cycle 17
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL to_ready got %b want 1", ready_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", rdata_o); end
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL to_req_drop got %b want 0000", slv_req_o); end
        req_i = 1'b0;
        slv_ready_i = 4'b0000;
        @(negedge clk_i);
        $display("read s2 addr=80001004: timeout err=1");
    endtask

    task automatic test_reset_mid_busy();
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_0020;
        @(negedge clk_i);  // cycle 1, BUSY
        checks++; if (slv_req_o !== 4'b0001) begin errors++; $display("FAIL rst_busy_req got %b want 0001", slv_req_o); end
        #1 arstn_i = 1'b0;
        #1;
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL rst_async_req got %b want 0000", slv_req_o); end
        checks++; if (slv_addr_o !== 32'h0) begin errors++; $display("FAIL rst_async_addr got %h want 0", slv_addr_o); end
        #1 arstn_i = 1'b1;
        req_i = 1'b0;
        // Late ready from the aborted slave lands in IDLE and must be ignored.
        slv_ready_i = 4'b0001;
        slv_rdata_i[31:0] = 32'h1111_1111;
        @(negedge clk_i);
        slv_ready_i = 4'b0000;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_stray_ready got %b want 0", ready_o); end
        checks++; if (slv_req_o !== 4'b0000) begin errors++; $display("FAIL rst_stray_req got %b want 0000", slv_req_o); end
        req_i = 1'b1;
        @(negedge clk_i);  // cycle 1 of reissued request
        checks++; if (slv_req_o !== 4'b0001) begin errors++; $display("FAIL re_slv_req got %b want 0001", slv_req_o); end
        checks++; if (slv_addr_o !== 32'h20) begin errors++; $display("FAIL re_slv_addr got %h want 20", slv_addr_o); end
        slv_ready_i = 4'b0001;
        slv_rdata_i[31:0] = 32'hCAFE_F00D;
        @(negedge clk_i);
        slv_ready_i = 4'b0000;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL re_ready got %b want 1", ready_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL re_err got %b want 0", err_o); end
        checks++; if (rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL re_rdata got %h want cafef00d", rdata_o); end
        req_i = 1'b0;
        @(negedge clk_i);
        $display("read s0 after mid-busy reset addr=00000020: rdata=%h", 32'hCAFE_F00D);
    endtask

    initial begin
        arstn_i     = 1'b0;
        req_i       = 1'b0;
        we_i        = 1'b0;
        be_i        = 4'h0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        slv_rdata_i = '0;
        slv_ready_i = 4'b0000;
        test_reset();
        test_read_s0();
        test_write_s1_wait();
        test_miss();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
